wb_bus_watchdog: RTL and testbench

WB_BUS_WATCHDOG -- requirements
Module: wb_bus_watchdog

---
 rtl/wb_bus_watchdog.sv | 150 +++++++++++++++
 tb/tb_wb_bus_watchdog.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_watchdog.sv
// Wishbone request watchdog: aborts hung requests with a one-cycle err.
// Optional fault logging is enabled by WB_BUS_WATCHDOG_FAULT_LOG_EN.
module wb_bus_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wbm_adr_i,
  input  logic [31:0] wbm_dat_i,
  input  logic [3:0]  wbm_sel_i,
  input  logic        wbm_we_i,
  input  logic        wbm_cyc_i,
  input  logic        wbm_stb_i,
  input  logic [2:0]  wbm_cti_i,
  input  logic [1:0]  wbm_bte_i,
  output logic [31:0] wbm_dat_o,
  output logic        wbm_ack_o,
  output logic        wbm_err_o,
  output logic        wbm_rty_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  output logic        wbs_we_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic [2:0]  wbs_cti_o,
  output logic [1:0]  wbs_bte_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i,
  input  logic        wbs_rty_i,
  output logic        fault_o,
  output logic [31:0] fault_adr_o,
  output logic [7:0]  fault_cnt_o,
  input  logic        fault_clr_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req;
  logic          rsp;
  logic          live;
  logic          enter_err;

  assign req = wbm_cyc_i & wbm_stb_i;
  assign rsp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = CW'(1);
        end
      end
      BUSY: begin
        if (!wbm_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rsp) begin
          cnt_d = '0;
        end else if (cnt_q == TMO) begin
          state_d = ERR;
          cnt_d   = '0;
        end else if (wbm_stb_i) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ERR: state_d = GAP;
      GAP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_err = (state_q == BUSY) && (state_d == ERR);

  // Slave side is only connected in IDLE/BUSY and outside reset
  assign live = wb_rst_n_i & ((state_q == IDLE) | (state_q == BUSY));

  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_sel_o = wbm_sel_i;
  assign wbs_we_o  = wbm_we_i;
  assign wbs_cti_o = wbm_cti_i;
  assign wbs_bte_o = wbm_bte_i;
  assign wbs_cyc_o = wbm_cyc_i & live;
  assign wbs_stb_o = wbm_stb_i & live;

  assign wbm_dat_o = live ? wbs_dat_i : '0;
  assign wbm_ack_o = wbs_ack_i & live;
  assign wbm_rty_o = wbs_rty_i & live;
  assign wbm_err_o = (wbs_err_i & live)
                   | (wb_rst_n_i & (state_q == ERR));

`ifdef WB_BUS_WATCHDOG_FAULT_LOG_EN
  logic        fault_q;
  logic [31:0] fadr_q;
  logic [7:0]  fcnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      fault_q <= 1'b0;
      fadr_q  <= '0;
      fcnt_q  <= '0;
    end else if (enter_err) begin
      fault_q <= 1'b1;
      fadr_q  <= wbm_adr_i;
      if (fcnt_q != 8'hFF) fcnt_q <= fcnt_q + 8'd1;
    end else if (fault_clr_i) begin
      fault_q <= 1'b0;
    end
  end

  assign fault_o     = fault_q;
  assign fault_adr_o = fadr_q;
  assign fault_cnt_o = fcnt_q;
`else
  logic unused_log;
  assign unused_log  = fault_clr_i & enter_err;
  assign fault_o     = 1'b0;
  assign fault_adr_o = '0;
  assign fault_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_bus_watchdog.sv
// Directed self-checking bench for wb_bus_watchdog, TIMEOUT=8.
module tb_wb_bus_watchdog;

`ifdef WB_BUS_WATCHDOG_FAULT_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic [31:0] m_dat_o;
  logic        m_ack_o, m_err_o, m_rty_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;
  logic        fault;
  logic [31:0] fault_adr;
  logic [7:0]  fault_cnt;
  logic        fclr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_bus_watchdog #(.TIMEOUT(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wbm_adr_i   (m_adr),
    .wbm_dat_i   (m_dat),
    .wbm_sel_i   (m_sel),
    .wbm_we_i    (m_we),
    .wbm_cyc_i   (m_cyc),
    .wbm_stb_i   (m_stb),
    .wbm_cti_i   (m_cti),
    .wbm_bte_i   (m_bte),
    .wbm_dat_o   (m_dat_o),
    .wbm_ack_o   (m_ack_o),
    .wbm_err_o   (m_err_o),
    .wbm_rty_o   (m_rty_o),
    .wbs_adr_o   (s_adr_o),
    .wbs_dat_o   (s_dat_o),
    .wbs_sel_o   (s_sel_o),
    .wbs_we_o    (s_we_o),
    .wbs_cyc_o   (s_cyc_o),
    .wbs_stb_o   (s_stb_o),
    .wbs_cti_o   (s_cti_o),
    .wbs_bte_o   (s_bte_o),
    .wbs_dat_i   (s_dat),
    .wbs_ack_i   (s_ack),
    .wbs_err_i   (s_err),
    .wbs_rty_i   (s_rty),
    .fault_o     (fault),
    .fault_adr_o (fault_adr),
    .fault_cnt_o (fault_cnt),
    .fault_clr_i (fclr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    m_cyc = 0; m_stb = 0;
    s_ack = 0; s_err = 0; s_rty = 0;
  endtask

  // Hung request: returns err seen in cycle 9, err seen anywhere else
  task automatic hung(input logic [31:0] a,
                      output logic e9, output logic eother);
    eother = 0;
    step(); m_cyc = 1; m_stb = 1; m_adr = a;
    #1 eother |= m_err_o;
    repeat (8) begin
      step(); #1 eother |= m_err_o;
    end
    step(); #1 e9 = m_err_o;
    step(); m_cyc = 0; m_stb = 0;
    #1 eother |= m_err_o;
    step(); #1 eother |= m_err_o;
  endtask

  logic e9, eo, eacc;
  int   acks;

  initial begin
    rst_n = 0; fclr = 0;
    m_adr = 0; m_dat = 0; m_sel = 4'hF; m_we = 0;
    m_cti = 0; m_bte = 0; s_dat = 0;
    idle_in();

    // Reset gating
    step(); m_cyc = 1; m_stb = 1; s_ack = 1; s_err = 1;
    #1;
    chk("rst_cyc", {31'd0, s_cyc_o}, 0);
    chk("rst_ack", {31'd0, m_ack_o}, 0);
    chk("rst_err", {31'd0, m_err_o}, 0);
    step(); rst_n = 1; idle_in();
    #1;
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_fcnt", {24'd0, fault_cnt}, 0);
    chk("rst_fadr", fault_adr, 0);

    // Read acked on wait cycle 3
    step();
    m_cyc = 1; m_stb = 1; m_adr = 32'h1000;
    m_sel = 4'h5; m_dat = 32'h1234_5678;
    #1;
    chk("pt_cyc", {31'd0, s_cyc_o}, 1);
    chk("pt_adr", s_adr_o, 32'h1000);
    chk("pt_sel", {28'd0, s_sel_o}, 32'h5);
    chk("pt_dat", s_dat_o, 32'h1234_5678);
    step(); step();
    step(); s_ack = 1; s_dat = 32'hCAFE_0001;
    #1;
    chk("rd_ack", {31'd0, m_ack_o}, 1);
    chk("rd_dat", m_dat_o, 32'hCAFE_0001);
    chk("rd_err", {31'd0, m_err_o}, 0);
    step(); idle_in();
    step(); #1;
    chk("rd_fcnt", {24'd0, fault_cnt}, 0);

    // Hung read at 0x3000
    step();
    m_cyc = 1; m_stb = 1; m_adr = 32'h3000; m_sel = 4'hF;
    s_dat = 32'h5555_AAAA;
    eacc = 0;
    for (int i = 1; i <= 8; i++) begin
      step(); #1 eacc |= m_err_o;
    end
    chk("to_noearly", {31'd0, eacc}, 0);
    chk("to_c8_cyc", {31'd0, s_cyc_o}, 1);
    step(); #1;
    chk("to_err", {31'd0, m_err_o}, 1);
    chk("to_err_cyc", {31'd0, s_cyc_o}, 0);
    chk("to_err_stb", {31'd0, s_stb_o}, 0);
    chk("to_err_dat", m_dat_o, 0);
    step(); s_ack = 1;
    #1;
    chk("gap_cyc", {31'd0, s_cyc_o}, 0);
    chk("gap_late_ack", {31'd0, m_ack_o}, 0);
    chk("gap_err", {31'd0, m_err_o}, 0);
    step(); idle_in();
    #1;
    chk("to_fault", {31'd0, fault}, {31'd0, LOG});
    chk("to_fadr", fault_adr, LOG ? 32'h3000 : 32'h0);
    chk("to_fcnt", {24'd0, fault_cnt}, LOG ? 1 : 0);

    // Ack exactly when counter hits TIMEOUT
    step(); m_cyc = 1; m_stb = 1; m_adr = 32'h2000;
    repeat (7) step();
    step(); s_ack = 1; s_dat = 32'h0BAD_F00D;
    #1;
    chk("edge_ack", {31'd0, m_ack_o}, 1);
    chk("edge_dat", m_dat_o, 32'h0BAD_F00D);
    step(); s_ack = 0;
    #1;
    chk("edge_noerr", {31'd0, m_err_o}, 0);
    chk("edge_cyc", {31'd0, s_cyc_o}, 1);
    step(); idle_in();
    step(); #1;
    chk("edge_fcnt", {24'd0, fault_cnt}, LOG ? 1 : 0);

    // 4-beat incrementing burst, each beat acked after 6 waits
    acks = 0; eacc = 0;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 7; w++) begin
        step();
        m_cyc = 1; m_stb = 1;
        m_adr = 32'h1400 + 32'(b * 4);
        m_cti = (b == 3) ? 3'b111 : 3'b010;
        s_ack = (w == 6);
        #1;
        if (b == 0 && w == 0) chk("bst_cti", {29'd0, s_cti_o}, 32'h2);
        acks += int'(m_ack_o);
        eacc |= m_err_o;
      end
    end
    chk("bst_acks", acks, 4);
    chk("bst_err", {31'd0, eacc}, 0);
    step(); idle_in(); m_cti = 0;
    step();

    // Reset in BUSY cycle 5 of a hung request
    step(); m_cyc = 1; m_stb = 1; m_adr = 32'h4000;
    repeat (4) step();
    step(); rst_n = 0;
    #1;
    chk("mrst_cyc", {31'd0, s_cyc_o}, 0);
    chk("mrst_err", {31'd0, m_err_o}, 0);
    step(); rst_n = 1;
    #1;
    chk("mrst_idle_cyc", {31'd0, s_cyc_o}, 1);
    chk("mrst_fault", {31'd0, fault}, 0);
    chk("mrst_fcnt", {24'd0, fault_cnt}, 0);
    eacc = m_err_o;
    repeat (7) begin
      step(); #1 eacc |= m_err_o;
    end
    chk("mrst_noerr", {31'd0, eacc}, 0);
    step(); idle_in();
    step();

    // 256 consecutive timeouts
    eacc = 0;
    acks = 0;
    for (int n = 0; n < 256; n++) begin
      hung(32'h5000 + 32'(n), e9, eo);
      acks += int'(e9);
      eacc |= eo;
    end
    chk("sat_err_n", acks, 256);
    chk("sat_stray", {31'd0, eacc}, 0);
    chk("sat_fcnt", {24'd0, fault_cnt}, LOG ? 255 : 0);
    chk("sat_fadr", fault_adr, LOG ? 32'h50FF : 32'h0);
    chk("sat_fault", {31'd0, fault}, {31'd0, LOG});
    step(); fclr = 1;
    step(); fclr = 0;
    #1;
    chk("clr_fault", {31'd0, fault}, 0);
    chk("clr_fcnt", {24'd0, fault_cnt}, LOG ? 255 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
